// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: single-outstanding command/response front end
// driving one AXI4-Lite read or write transaction at a time.
//
// Ports:
//   axi_clk, axi_a_rst_n          clock, async active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_we, cmd_addr,
//   cmd_wdata, cmd_wstrb          command payload (wdata/wstrb for writes only)
//   rsp_valid                     one-cycle completion pulse
//   rsp_we, rsp_rdata, rsp_resp   completion payload, held until next completion
//   m_axi_*                       AXI4-Lite master channels AW, W, B, AR, R

module axi_lite_master #(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 4,
    parameter logic [2:0]  PROT           = 3'b000
) (
    input  logic                          axi_clk,
    input  logic                          axi_a_rst_n,

    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_we,
    input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                          rsp_valid,
    output logic                          rsp_we,
    output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                    rsp_resp,

    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,

    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,

    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,

    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,

    input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int unsigned DW = AXI_DATA_WIDTH;
    localparam int unsigned AW = AXI_ADDR_WIDTH;
    localparam int unsigned SW = AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_e;

    state_e          state_q, state_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            rsp_we_q, rsp_we_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_resp_q, rsp_resp_d;

    logic            aw_hs;
    logic            w_hs;

    // Channel controls are decoded from registered state only, so no
    // valid ever depends combinationally on a ready.
    assign cmd_ready     = (state_q == IDLE);
    assign m_axi_awvalid = (state_q == WR) && !aw_done_q;
    assign m_axi_wvalid  = (state_q == WR) && !w_done_q;
    assign m_axi_bready  = (state_q == WR_RESP);
    assign m_axi_arvalid = (state_q == RD_ADDR);
    assign m_axi_rready  = (state_q == RD_DATA);
    assign rsp_valid     = (state_q == RESP);

    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_awprot  = PROT;
    assign m_axi_arprot  = PROT;

    assign rsp_we        = rsp_we_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;

    always_ff @(posedge axi_clk or negedge axi_a_rst_n) begin
        if (!axi_a_rst_n) begin
            state_q     <= IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_we_d    = rsp_we_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_we ? WR : RD_ADDR;
                end
            end

            WR: begin
                // AW and W complete independently, possibly together.
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end

            WR_RESP: begin
                if (m_axi_bvalid) begin
                    rsp_we_d    = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axi_bresp;
                    state_d     = RESP;
                end
            end

            RD_ADDR: begin
                if (m_axi_arready) begin
                    state_d = RD_DATA;
                end
            end

            RD_DATA: begin
                if (m_axi_rvalid) begin
                    rsp_we_d    = 1'b0;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    state_d     = RESP;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed self-checking bench for axi_lite_master with a small
// behavioural AXI4-Lite slave whose ready/valid delays are adjustable.

module tb_axi_lite_master;

    logic        clk;
    logic        rst_n;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_we;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int errors = 0;
    int checks = 0;

    axi_lite_master #(
        .AXI_DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(4),
        .PROT          (3'b000)
    ) dut (
        .axi_clk      (clk),
        .axi_a_rst_n  (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_we       (cmd_we),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_we       (rsp_we),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .m_axi_awaddr (awaddr),
        .m_axi_awprot (awprot),
        .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata  (wdata),
        .m_axi_wstrb  (wstrb),
        .m_axi_wvalid (wvalid),
        .m_axi_wready (wready),
        .m_axi_bresp  (bresp),
        .m_axi_bvalid (bvalid),
        .m_axi_bready (bready),
        .m_axi_araddr (araddr),
        .m_axi_arprot (arprot),
        .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata  (rdata),
        .m_axi_rresp  (rresp),
        .m_axi_rvalid (rvalid),
        .m_axi_rready (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural slave ----------------
    int          aw_delay = 0;
    int          w_delay  = 0;
    int          b_delay  = 0;
    int          ar_delay = 0;
    int          r_delay  = 0;
    logic [1:0]  bresp_cfg = 2'b00;

    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic        aw_got, w_got, b_pend, r_pend;
    logic [3:0]  s_awaddr, s_araddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] mem [4];

    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [3:0]  e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;

    assign awready = awvalid && (aw_cnt >= aw_delay);
    assign wready  = wvalid && (w_cnt >= w_delay);
    assign arready = arvalid && (ar_cnt >= ar_delay);
    assign bvalid  = b_pend && (b_cnt >= b_delay);
    assign rvalid  = r_pend && (r_cnt >= r_delay);
    assign bresp   = b_pend ? bresp_cfg : 2'b00;
    assign rresp   = 2'b00;
    assign rdata   = r_pend ? mem[s_araddr[3:2]] : 32'h0;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;
    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    assign e_addr  = aw_hs ? awaddr : s_awaddr;
    assign e_wdata = w_hs ? wdata : s_wdata;
    assign e_wstrb = w_hs ? wstrb : s_wstrb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt   <= 0;
            w_cnt    <= 0;
            b_cnt    <= 0;
            ar_cnt   <= 0;
            r_cnt    <= 0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            b_pend   <= 1'b0;
            r_pend   <= 1'b0;
            s_awaddr <= 4'h0;
            s_araddr <= 4'h0;
            s_wdata  <= 32'h0;
            s_wstrb  <= 4'h0;
            mem[0]   <= 32'h1111_1111;
            mem[1]   <= 32'h2222_2222;
            mem[2]   <= 32'hCAFE_F00D;
            mem[3]   <= 32'h0BAD_C0DE;
        end else begin
            if (aw_hs) aw_cnt <= 0;
            else if (awvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs) w_cnt <= 0;
            else if (wvalid) w_cnt <= w_cnt + 1;
            if (ar_hs) ar_cnt <= 0;
            else if (arvalid) ar_cnt <= ar_cnt + 1;
            if (b_hs) b_cnt <= 0;
            else if (b_pend) b_cnt <= b_cnt + 1;
            if (r_hs) r_cnt <= 0;
            else if (r_pend) r_cnt <= r_cnt + 1;

            if (aw_hs) s_awaddr <= awaddr;
            if (w_hs) begin
                s_wdata <= wdata;
                s_wstrb <= wstrb;
            end

            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                b_pend <= 1'b1;
                if (bresp_cfg == 2'b00) begin
                    for (int i = 0; i < 4; i++) begin
                        if (e_wstrb[i])
                            mem[e_addr[3:2]][8*i +: 8] <= e_wdata[8*i +: 8];
                    end
                end
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs) w_got <= 1'b1;
            end
            if (b_hs) b_pend <= 1'b0;

            if (ar_hs) begin
                r_pend   <= 1'b1;
                s_araddr <= araddr;
            end
            if (r_hs) r_pend <= 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Returns at the falling edge of cycle 1 (cycle 0 is the accept cycle).
    task automatic send(input logic we, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: cmd_ready=%b want 1", cmd_ready);
        end
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Steps falling edges until rsp_valid; n is the cycle index reached.
    task automatic wait_rsp(inout int n, output bit ok);
        ok = 1'b0;
        while (n < 60) begin
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 4'h0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_we}
            !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 0",
                     {awvalid, wvalid, bready, arvalid, rready,
                      rsp_valid, rsp_we});
        end
        checks++;
        if ({rsp_rdata, rsp_resp, awaddr, wdata, wstrb, araddr,
             awprot, arprot} !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h resp=%b awaddr=%h wdata=%h wstrb=%h araddr=%h",
                     rsp_rdata, rsp_resp, awaddr, wdata, wstrb, araddr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_basic();
        send(1'b1, 4'h4, 32'hDEAD_BEEF, 4'hF, 1'b0);
        checks++;
        if ({awvalid, wvalid, bready, rsp_valid} !== 4'b1100 ||
            awaddr !== 4'h4 || wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF) begin
            errors++;
            $display("FAIL wr_cycle1: aw/w/b/rsp=%b want 1100 addr=%h data=%h strb=%h",
                     {awvalid, wvalid, bready, rsp_valid}, awaddr, wdata, wstrb);
        end
        @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin
            errors++;
            $display("FAIL wr_cycle2: aw/w/b/rsp=%b want 0010",
                     {awvalid, wvalid, bready, rsp_valid});
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_we !== 1'b1 ||
            rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL wr_cycle3_rsp: valid=%b we=%b resp=%b rdata=%h want 1 1 00 0",
                     rsp_valid, rsp_we, rsp_resp, rsp_rdata);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_cycle4_idle: rsp_valid=%b cmd_ready=%b want 0 1",
                     rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_read_basic();
        send(1'b0, 4'h8, 32'h0, 4'h0, 1'b0);
        checks++;
        if (arvalid !== 1'b1 || araddr !== 4'h8 || rready !== 1'b0) begin
            errors++;
            $display("FAIL rd_cycle1: arvalid=%b araddr=%h rready=%b want 1 8 0",
                     arvalid, araddr, rready);
        end
        @(negedge clk);
        checks++;
        if (arvalid !== 1'b0 || rready !== 1'b1) begin
            errors++;
            $display("FAIL rd_cycle2: arvalid=%b rready=%b want 0 1",
                     arvalid, rready);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 ||
            rsp_resp !== 2'b00 || rsp_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rd_cycle3_rsp: valid=%b we=%b resp=%b rdata=%h want 1 0 00 cafef00d",
                     rsp_valid, rsp_we, rsp_resp, rsp_rdata);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rd_hold: valid=%b rdata=%h want 0 cafef00d",
                     rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_aw_delay();
        int  aw_n, w_n, b_first, rsp_c, bad;
        int  n;
        bit  ok;
        aw_n = 0; w_n = 0; b_first = 0; rsp_c = 0; bad = 0;
        aw_delay = 3;
        send(1'b1, 4'hC, 32'h1234_5678, 4'h3, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            if (awvalid) begin
                aw_n++;
                if (awaddr !== 4'hC || wdata !== 32'h1234_5678 ||
                    wstrb !== 4'h3) bad++;
            end
            if (wvalid) w_n++;
            if (bready && b_first == 0) begin
                b_first = c;
                if (awvalid || wvalid) bad++;
            end
            if (rsp_valid) begin
                rsp_c = c;
                break;
            end
            @(negedge clk);
        end
        aw_delay = 0;
        checks++;
        if (w_n != 1) begin
            errors++;
            $display("FAIL awdly_wvalid_cycles: got %0d want 1", w_n);
        end
        checks++;
        if (aw_n != 4) begin
            errors++;
            $display("FAIL awdly_awvalid_cycles: got %0d want 4", aw_n);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL awdly_stable: %0d unstable cycles want 0", bad);
        end
        checks++;
        if (b_first != 5 || rsp_c != 6) begin
            errors++;
            $display("FAIL awdly_timing: bready@%0d rsp@%0d want 5 6",
                     b_first, rsp_c);
        end
        // Read back to confirm address and byte strobes reached the slave.
        send(1'b0, 4'hC, 32'h0, 4'h0, 1'b0);
        n = 1;
        wait_rsp(n, ok);
        checks++;
        if (!ok || rsp_rdata !== 32'h0BAD_5678) begin
            errors++;
            $display("FAIL awdly_readback: ok=%b rdata=%h want 1 0bad5678",
                     ok, rsp_rdata);
        end
    endtask

    task automatic test_bresp_err();
        int n;
        bit ok;
        bresp_cfg = 2'b10;
        send(1'b1, 4'h0, 32'hFFFF_FFFF, 4'hF, 1'b0);
        n = 1;
        wait_rsp(n, ok);
        checks++;
        if (!ok || rsp_resp !== 2'b10 || rsp_we !== 1'b1 ||
            rsp_rdata !== 32'h0 || n != 3) begin
            errors++;
            $display("FAIL slverr_wr: ok=%b resp=%b we=%b rdata=%h cyc=%0d want 1 10 1 0 3",
                     ok, rsp_resp, rsp_we, rsp_rdata, n);
        end
        bresp_cfg = 2'b00;
        send(1'b0, 4'h4, 32'h0, 4'h0, 1'b0);
        n = 1;
        wait_rsp(n, ok);
        checks++;
        if (!ok || rsp_resp !== 2'b00 || rsp_we !== 1'b0 ||
            rsp_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL slverr_next_rd: ok=%b resp=%b we=%b rdata=%h want 1 00 0 deadbeef",
                     ok, rsp_resp, rsp_we, rsp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int  busy_bad, rsp_c, n;
        bit  ok;
        busy_bad = 0;
        rsp_c = 0;
        r_delay = 5;
        send(1'b0, 4'h0, 32'h0, 4'h0, 1'b1);
        cmd_addr = 4'h8;
        for (int c = 1; c <= 20; c++) begin
            if (cmd_ready !== 1'b0) busy_bad++;
            if (rsp_valid) begin
                rsp_c = c;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (busy_bad != 0 || rsp_c != 8 || rsp_rdata !== 32'h1111_1111) begin
            errors++;
            $display("FAIL b2b_first: busy_bad=%0d rsp@%0d rdata=%h want 0 8 11111111",
                     busy_bad, rsp_c, rsp_rdata);
        end
        r_delay = 0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_after_rsp: cmd_ready=%b rsp_valid=%b want 1 0",
                     cmd_ready, rsp_valid);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (arvalid !== 1'b1 || araddr !== 4'h8 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: arvalid=%b araddr=%h cmd_ready=%b want 1 8 0",
                     arvalid, araddr, cmd_ready);
        end
        n = 1;
        wait_rsp(n, ok);
        checks++;
        if (!ok || rsp_rdata !== 32'hCAFE_F00D || n != 3) begin
            errors++;
            $display("FAIL b2b_second_rsp: ok=%b rdata=%h cyc=%0d want 1 cafef00d 3",
                     ok, rsp_rdata, n);
        end
    endtask

    task automatic test_reset_mid();
        int bad, n;
        bit ok;
        bad = 0;
        ar_delay = 10;
        send(1'b0, 4'hC, 32'h0, 4'h0, 1'b0);
        checks++;
        if (arvalid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: arvalid=%b want 1", arvalid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({arvalid, rready, rsp_valid} !== 3'b000 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async: ar/r/rsp=%b cmd_ready=%b want 000 1",
                     {arvalid, rready, rsp_valid}, cmd_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ar_delay = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 ||
                arvalid !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rstmid_no_rsp: %0d bad cycles want 0", bad);
        end
        send(1'b0, 4'h8, 32'h0, 4'h0, 1'b0);
        n = 1;
        wait_rsp(n, ok);
        checks++;
        if (!ok || rsp_rdata !== 32'hCAFE_F00D || rsp_resp !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_recover: ok=%b rdata=%h resp=%b want 1 cafef00d 00",
                     ok, rsp_rdata, rsp_resp);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_aw_delay();
        test_bresp_err();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
